// File: rtl/dar_pkg.sv
// Shared widths and encodings for the dar register file and its arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dar_pkg;

    localparam int DAR_DATA_W = 8;
    localparam int DAR_ADDR_W = 2;

    // Arbiter sequencing states: accept, drive the register file, respond.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } dar_state_e;

    // Which client owns the command currently in flight.
    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } dar_owner_e;

endpackage

// File: rtl/dar_arb_if.sv
// Client command/response handshakes plus the register file port of dar_arb.
// Latency: n/a (wiring only).
// Backpressure: reqN_ready qualifies reqN_valid; responses are unthrottled pulses.
interface dar_arb_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic              req0_valid;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic              req1_valid;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;
    logic              rf_w_en;
    logic              rf_r_en;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata;

    // Client side (and register file read data source).
    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output rf_rdata,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
        input  rf_w_en, rf_r_en, rf_addr, rf_wdata
    );

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  rf_rdata,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
        output rf_w_en, rf_r_en, rf_addr, rf_wdata
    );
endinterface

// File: rtl/dar_rr_pick.sv
// Two-way winner picker; round-robin on ties, or fixed priority to requester 0
// when DAR_ARB_FIXED_PRIO_EN is defined. Latency: combinational, zero cycles.
// Backpressure: none; gnt is meaningful only while any is high.
module dar_rr_pick (
    input  logic v0,
    input  logic v1,
    input  logic last,
    output logic gnt,
    output logic any
);

    assign any = v0 | v1;

`ifdef DAR_ARB_FIXED_PRIO_EN
    // Requester 0 always wins; the round-robin pointer is ignored.
    logic unused_last;
    assign unused_last = last;
    assign gnt = ~v0 & v1;
`else
    // On a tie the requester that did not win last time goes next.
    assign gnt = (v0 & v1) ? ~last : v1;
`endif

endmodule

// File: rtl/dar_arb.sv
// Two-client arbiter/sequencer for the dar register file (optional DAR_ARB_FIXED_PRIO_EN).
// Latency: accept in cycle 0, rf access in cycle 1, response pulse in cycle 2; one command per 3 cycles.
// Backpressure: ready only in IDLE to the single winner; losers hold valid until accepted.
module dar_arb
    import dar_pkg::*;
#(
    parameter int DATA_W = DAR_DATA_W,
    parameter int ADDR_W = DAR_ADDR_W
) (
    input  logic      clk,
    input  logic      rst,
    dar_arb_if.slave  bus
);

    dar_state_e        state_q, state_d;
    dar_owner_e        owner_q, owner_d;
    logic              last_q,  last_d;
    logic              we_q,    we_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              gnt;
    logic              any;

    dar_rr_pick u_pick (
        .v0   (bus.req0_valid),
        .v1   (bus.req1_valid),
        .last (last_q),
        .gnt  (gnt),
        .any  (any)
    );

    // State, round-robin pointer and command latch; reset aborts any command in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= REQ0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state, accept/latch, register file drive and response decode.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_d         = last_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp0_valid = 1'b0;
        bus.rsp0_rdata = '0;
        bus.rsp1_valid = 1'b0;
        bus.rsp1_rdata = '0;
        bus.rf_w_en    = 1'b0;
        bus.rf_r_en    = 1'b0;
        bus.rf_addr    = '0;
        bus.rf_wdata   = '0;
        case (state_q)
            IDLE: begin
                if (any) begin
                    if (gnt) begin
                        bus.req1_ready = 1'b1;
                        we_d           = bus.req1_we;
                        addr_d         = bus.req1_addr;
                        wdata_d        = bus.req1_wdata;
                    end else begin
                        bus.req0_ready = 1'b1;
                        we_d           = bus.req0_we;
                        addr_d         = bus.req0_addr;
                        wdata_d        = bus.req0_wdata;
                    end
                    owner_d = dar_owner_e'(gnt);
                    last_d  = gnt;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                bus.rf_addr  = addr_q;
                bus.rf_wdata = wdata_q;
                bus.rf_w_en  = we_q;
                bus.rf_r_en  = ~we_q;
                state_d      = RESP;
            end
            RESP: begin
                // rf_rdata was loaded by the ISSUE edge; writes answer with zero.
                if (owner_q == REQ1) begin
                    bus.rsp1_valid = 1'b1;
                    bus.rsp1_rdata = we_q ? '0 : bus.rf_rdata;
                end else begin
                    bus.rsp0_valid = 1'b1;
                    bus.rsp0_rdata = we_q ? '0 : bus.rf_rdata;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/dar_arb.md
# dar_arb

Two-requester arbiter and sequencer for the 4×8 `dar` register file. Two independent clients issue single-word read or write commands over a valid/ready handshake. The block serialises the commands with round-robin priority, drives the register file's `w_en`/`r_en`/`addr`/`data_in` for exactly one cycle per command, and returns a per-requester response pulse carrying read data. It sits between the clients and a single `dar` instance and is that instance's only driver.

## Interface
- `DATA_W`, default 8: data width; matches register file width.
- `ADDR_W`, default 2: address width; 4 entries.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0_valid`, `req1_valid` in 1: command present.
- `req0_we`, `req1_we` in 1: 1 = write, 0 = read.
- `req0_addr`, `req1_addr` in ADDR_W: target entry.
- `req0_wdata`, `req1_wdata` in DATA_W: write data.
- `req0_ready`, `req1_ready` out 1: command accepted this cycle (transfer = valid & ready).
- `rsp0_valid`, `rsp1_valid` out 1: one-cycle completion pulse.
- `rsp0_rdata`, `rsp1_rdata` out DATA_W: read data; 0 for writes and when not valid.
- `rf_w_en`, `rf_r_en` out 1: register file enables; never both high.
- `rf_addr` out ADDR_W: register file address.
- `rf_wdata` out DATA_W: register file write data.
- `rf_rdata` in DATA_W: register file registered read output.

## Operation
- FSM has three states:
  - IDLE: if any `reqN_valid` is high, pick a winner, assert that requester's `reqN_ready` combinationally, latch `we`/`addr`/`wdata`/owner, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: drive `rf_addr` and `rf_wdata` from the latch. Assert `rf_w_en` if `we`, else `rf_r_en`, for this single cycle. Go to RESP.
  - RESP: assert `rsp<owner>_valid`. For reads, `rsp<owner>_rdata` = `rf_rdata` (updated by the ISSUE edge); for writes it is 0. Go to IDLE.
- Arbitration is round-robin with a 1-bit `last` pointer:
  - Only one valid: that requester wins.
  - Both valid: the requester ≠ `last` wins.
  - `last` updates on each accept.
- `ready` is low outside IDLE. At most one `ready` is high per cycle.
- Requesters hold their command stable while `valid` is high and not accepted. Deasserting `valid` before acceptance withdraws the command; no side effect.
- The latched command is immune to requester input changes after acceptance.
- `rf_*` outputs are 0 in IDLE and RESP.

## Timing
- Accept edge at cycle 0 → ISSUE in cycle 1 → RESP in cycle 2 (`rsp_valid` high) → IDLE in cycle 3, when a new accept is possible.
- Peak throughput is one command per 3 cycles.
- Write is visible in the register file after the cycle-1 edge. A read issued by either requester in a later command returns the new value.
- Back-to-back requests from both clients alternate 0,1,0,1…; neither waits more than one other command.
- Reset values: state=IDLE, `last`=1 (requester 0 wins first tie), latch=0, all `ready`/`rsp_valid`/`rf_*` outputs 0, `rdata` 0.
- Reset asserted mid-command (ISSUE or RESP):
  - Abort immediately.
  - No `rsp_valid` is produced for the aborted command.
  - The register file is cleared by the same `rst`.

## Configuration
- `DAR_ARB_FIXED_PRIO_EN`:
  - Defined: requester 0 always wins ties and `last` is not used. Requester 1 may starve.
  - Undefined (default): round-robin as specified.
- No other behaviour changes.

## Structure
- Shared package `dar_pkg` holds:
  - `DAR_DATA_W`=8 and `DAR_ADDR_W`=2.
  - State encodings: IDLE=2'd0, ISSUE=2'd1, RESP=2'd2.
  - Owner encoding: REQ0=1'b0, REQ1=1'b1.
- Sub-module `dar_rr_pick` is the pure combinational two-way picker. Inputs are `v0`, `v1`, `last`; outputs are `gnt`, `any`. It contains the `DAR_ARB_FIXED_PRIO_EN` switch.
- FSM, command latch and response decode stay in `dar_arb`.

## Test plan
- Reset then idle: `rst` pulse → all outputs 0. A read of each of the 4 addresses returns `rdata`=0x00.
- Single write/read: req0 writes 0xA5 to addr 2 → `req0_ready` at cycle 0, `rf_w_en`=1 with addr 2 in cycle 1, `rsp0_valid` in cycle 2 with `rdata` 0. Then req1 reads addr 2 → `rsp1_rdata`=0xA5.
- Simultaneous contention: both requesters continuously valid, each writing its own ID to addr 0 and 1 → grants alternate 0,1,0,1. First accept goes to req0. Gap between accepts is 3 cycles.
- Withdraw: req1 valid for 1 cycle while the block is in ISSUE, then dropped → never accepted, no `rf` activity, no `rsp1_valid`.
- Reset mid-command: assert `rst` during ISSUE of a read → no `rsp_valid`. State returns to IDLE. A next req1 read of that address returns 0x00.
- With `DAR_ARB_FIXED_PRIO_EN`: both continuously valid → req0 accepted every 3 cycles, `req1_ready` never high.
